// File: rtl/hdmi_pattern_ctrl_pkg.sv
// Shared definitions for the HDMI pattern controller: source indices, FSM
// states, 800x525 raster constants and the pattern wrap helper.
package hdmi_pkg;

  localparam logic [1:0] PAT_WHEEL = 2'd0;
  localparam logic [1:0] PAT_TEST  = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  localparam int unsigned H_TOTAL  = 32'd800;
  localparam int unsigned V_TOTAL  = 32'd525;
  localparam int unsigned H_ACTIVE = 32'd640;
  localparam int unsigned V_ACTIVE = 32'd480;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    SWITCH  = 2'd2
  } state_t;

  function automatic logic [1:0] pattern_next(input logic [1:0] sel, input int unsigned num);
    if (32'(sel) >= num - 32'd1) begin
      return 2'd0;
    end else begin
      return sel + 2'd1;
    end
  endfunction

endpackage

// File: rtl/hdmi_pattern_ctrl_btn_debounce.sv
// Active-low push-button conditioner: 2-FF synchroniser, stability counter,
// one-cycle pulse when a press (accepted 1->0 transition) is recognised.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 252000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Synchronise, then accept the new level only after it stays put long enough.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/hdmi_pattern_ctrl.sv
// Frame-synchronous source selector: blanks after reset and for one frame per
// switch, paces hue stepping. Define HDMI_AUTO_CYCLE_EN for idle auto-advance.
module hdmi_pattern_ctrl
  import hdmi_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS    = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 252000,
  parameter int unsigned STARTUP_FRAMES  = 2,
  parameter int unsigned HUE_DIV         = 4,
  parameter int unsigned AUTO_FRAMES     = 300
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn,
  input  logic       frame_start,
  output logic [1:0] pattern_sel,
  output logic       blank,
  output logic       hue_step,
  output logic       busy
);

  localparam int unsigned SW = (STARTUP_FRAMES > 1) ? $clog2(STARTUP_FRAMES) : 1;
  localparam int unsigned HW = (HUE_DIV > 1) ? $clog2(HUE_DIV) : 1;
  localparam logic [SW-1:0] S_MAX = SW'(STARTUP_FRAMES - 1);
  localparam logic [HW-1:0] H_MAX = HW'(HUE_DIV - 1);

  state_t        r_state,       w_state_nx;
  logic [1:0]    r_pattern_sel, w_pattern_nx;
  logic          r_blank,       w_blank_nx;
  logic          r_hue_step,    w_hue_step_nx;
  logic          r_busy,        w_busy_nx;
  logic          r_pending,     w_pending_nx;
  logic [SW-1:0] r_startup_cnt, w_startup_nx;
  logic [HW-1:0] r_hue_cnt,     w_hue_cnt_nx;
  logic          w_press;
  logic          w_auto_due;
  logic          w_advance;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_btn_n (btn),
    .o_press (w_press)
  );

`ifdef HDMI_AUTO_CYCLE_EN
  localparam int unsigned AW = $clog2(AUTO_FRAMES + 1);
  localparam logic [AW-1:0] A_MAX = AW'(AUTO_FRAMES);

  logic [AW-1:0] r_auto_cnt, w_auto_nx;

  assign w_auto_due = (r_auto_cnt == A_MAX);

  // Idle-frame count in RUN; saturates at the trigger value, any press or advance restarts it.
  always_comb begin
    w_auto_nx = r_auto_cnt;
    if (w_advance || w_press) begin
      w_auto_nx = '0;
    end else if (frame_start && (r_state == RUN) && (r_auto_cnt != A_MAX)) begin
      w_auto_nx = r_auto_cnt + AW'(1);
    end else begin
      w_auto_nx = r_auto_cnt;
    end
  end

  // Auto-advance counter register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= w_auto_nx;
    end
  end
`else
  assign w_auto_due = 1'b0;
`endif

  assign w_advance = frame_start && (r_state == RUN) && (r_pending || w_auto_due);

  // Next-state and next-output logic; everything moves only on frame_start.
  always_comb begin
    w_state_nx    = r_state;
    w_pattern_nx  = r_pattern_sel;
    w_blank_nx    = r_blank;
    w_hue_step_nx = 1'b0;
    w_pending_nx  = r_pending | w_press;
    w_startup_nx  = r_startup_cnt;
    w_hue_cnt_nx  = r_hue_cnt;
    case (r_state)
      STARTUP: begin
        w_blank_nx = 1'b1;
        if (frame_start && (r_startup_cnt == S_MAX)) begin
          w_state_nx   = RUN;
          w_blank_nx   = 1'b0;
          w_startup_nx = '0;
        end else if (frame_start) begin
          w_startup_nx = r_startup_cnt + SW'(1);
        end else begin
          w_startup_nx = r_startup_cnt;
        end
      end
      RUN: begin
        w_blank_nx = 1'b0;
        if (w_advance) begin
          // A press arriving on the advance cycle is absorbed by this switch.
          w_state_nx   = SWITCH;
          w_blank_nx   = 1'b1;
          w_pattern_nx = pattern_next(r_pattern_sel, NUM_PATTERNS);
          w_pending_nx = 1'b0;
        end else if (frame_start && (r_pattern_sel == PAT_WHEEL)) begin
          if (r_hue_cnt == H_MAX) begin
            w_hue_cnt_nx  = '0;
            w_hue_step_nx = 1'b1;
          end else begin
            w_hue_cnt_nx = r_hue_cnt + HW'(1);
          end
        end else begin
          w_hue_cnt_nx = r_hue_cnt;
        end
      end
      SWITCH: begin
        w_blank_nx = 1'b1;
        if (frame_start) begin
          w_state_nx = RUN;
          w_blank_nx = 1'b0;
        end else begin
          w_state_nx = SWITCH;
        end
      end
      default: begin
        w_state_nx = STARTUP;
        w_blank_nx = 1'b1;
      end
    endcase
    w_busy_nx = w_pending_nx | (w_state_nx != RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= STARTUP;
      r_pattern_sel <= PAT_WHEEL;
      r_blank       <= 1'b1;
      r_hue_step    <= 1'b0;
      r_busy        <= 1'b1;
      r_pending     <= 1'b0;
      r_startup_cnt <= '0;
      r_hue_cnt     <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_pattern_sel <= w_pattern_nx;
      r_blank       <= w_blank_nx;
      r_hue_step    <= w_hue_step_nx;
      r_busy        <= w_busy_nx;
      r_pending     <= w_pending_nx;
      r_startup_cnt <= w_startup_nx;
      r_hue_cnt     <= w_hue_cnt_nx;
    end
  end

  assign pattern_sel = r_pattern_sel;
  assign blank       = r_blank;
  assign hue_step    = r_hue_step;
  assign busy        = r_busy;

endmodule

// File: tb/tb_hdmi_pattern_ctrl.sv
// Directed bench for hdmi_pattern_ctrl; frame_start every 100 cycles.
// Runs the auto-advance sequence instead when HDMI_AUTO_CYCLE_EN is defined.
module tb_hdmi_pattern_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       btn;
  logic       frame_start;
  logic [1:0] pattern_sel;
  logic       blank;
  logic       hue_step;
  logic       busy;

  int         n_checks = 0;
  int         n_fail = 0;
  int         fcnt;
  logic       fs_edge;
  logic       rst_edge;
  logic [1:0] prev_sel;
  int         hue_pulses;
  int         hue_misaligned;
  int         mid_changes;

  always #5 clk_in = ~clk_in;

  hdmi_pattern_ctrl #(
    .NUM_PATTERNS    (4),
    .DEBOUNCE_CYCLES (8),
    .STARTUP_FRAMES  (2),
    .HUE_DIV         (4),
    .AUTO_FRAMES     (5)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .btn         (btn),
    .frame_start (frame_start),
    .pattern_sel (pattern_sel),
    .blank       (blank),
    .hue_step    (hue_step),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge, then schedule frame_start for the next edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
    fs_edge  = frame_start;
    rst_edge = rst_in;
    if (hue_step === 1'b1) begin
      hue_pulses++;
      if (!fs_edge) hue_misaligned++;
    end
    if ((pattern_sel !== prev_sel) && !fs_edge && !rst_edge) mid_changes++;
    prev_sel    = pattern_sel;
    fcnt        = (fcnt == 99) ? 0 : fcnt + 1;
    frame_start = (fcnt == 99);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Stops just after the edge that sampled frame_start (at most 100 cycles).
  task automatic to_frame();
    cyc();
    while (fs_edge !== 1'b1) cyc();
  endtask

  task automatic press_release();
    cycles(10);
    btn = 1'b0;
    cycles(20);
    btn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    btn = 1'b1;
    fcnt = 95;
    frame_start = 1'b0;
    prev_sel = 2'd0;
    hue_pulses = 0;
    hue_misaligned = 0;
    mid_changes = 0;

    // Reset held across a frame_start strobe: reset wins.
    cycles(6);
    chk("rst_pattern", pattern_sel, 8'd0);
    chk("rst_blank", blank, 8'd1);
    chk("rst_hue", hue_step, 8'd0);
    chk("rst_busy", busy, 8'd1);
    rst_in = 1'b0;

    to_frame();
    chk("startup1_blank", blank, 8'd1);
    chk("startup1_busy", busy, 8'd1);
    cycles(50);
    chk("startup_mid_blank", blank, 8'd1);
    to_frame();
    chk("startup2_blank", blank, 8'd0);
    chk("startup2_busy", busy, 8'd0);
    chk("startup2_pattern", pattern_sel, 8'd0);

`ifdef HDMI_AUTO_CYCLE_EN
    for (int k = 0; k < 5; k++) begin
      to_frame();
      chk("auto_idle_sel", pattern_sel, 8'd0);
    end
    to_frame();
    chk("auto_adv_sel", pattern_sel, 8'd1);
    chk("auto_adv_blank", blank, 8'd1);
    to_frame();
    chk("auto_run_blank", blank, 8'd0);
    for (int k = 0; k < 5; k++) begin
      to_frame();
      chk("auto_idle2_sel", pattern_sel, 8'd1);
    end
    press_release();
    cycles(20);
    chk("auto_press_busy", busy, 8'd1);
    to_frame();
    chk("auto_press_sel", pattern_sel, 8'd2);
    chk("auto_press_blank", blank, 8'd1);
    to_frame();
    chk("auto_single_blank", blank, 8'd0);
    chk("auto_single_busy", busy, 8'd0);
    to_frame();
    chk("auto_single_sel", pattern_sel, 8'd2);
`else
    // Hue pacing on the wheel pattern: one pulse every 4 frames.
    hue_pulses = 0;
    hue_misaligned = 0;
    for (int k = 0; k < 12; k++) begin
      to_frame();
      chk("hue_step_frame", hue_step, ((k % 4) == 3) ? 8'd1 : 8'd0);
    end
    chk("hue_count", 8'(hue_pulses), 8'd3);
    chk("hue_align", 8'(hue_misaligned), 8'd0);

    // Clean press mid-frame: pending 11 cycles after btn falls.
    cycles(20);
    btn = 1'b0;
    cycles(10);
    chk("pend_early", busy, 8'd0);
    cyc();
    chk("pend_latency", busy, 8'd1);
    chk("press_midframe_sel", pattern_sel, 8'd0);
    chk("press_midframe_blank", blank, 8'd0);
    to_frame();
    chk("switch_sel", pattern_sel, 8'd1);
    chk("switch_blank", blank, 8'd1);
    chk("switch_busy", busy, 8'd1);
    cycles(30);
    btn = 1'b1;
    cycles(30);
    chk("switch_mid_blank", blank, 8'd1);
    to_frame();
    chk("after_switch_blank", blank, 8'd0);
    chk("after_switch_busy", busy, 8'd0);
    chk("after_switch_sel", pattern_sel, 8'd1);

    // Bounce of 3-cycle pulses, then held low: one advance only.
    cycles(10);
    for (int i = 0; i < 40; i++) begin
      btn = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
      cyc();
    end
    btn = 1'b0;
    cycles(15);
    chk("bounce_pending", busy, 8'd1);
    to_frame();
    chk("bounce_adv_sel", pattern_sel, 8'd2);
    cycles(20);
    btn = 1'b1;
    to_frame();
    chk("bounce_run_blank", blank, 8'd0);
    to_frame();
    chk("bounce_single_sel", pattern_sel, 8'd2);
    chk("bounce_single_busy", busy, 8'd0);

    // No hue pulses on the bars pattern.
    hue_pulses = 0;
    for (int k = 0; k < 8; k++) to_frame();
    chk("hue_bars_count", 8'(hue_pulses), 8'd0);

    // Reset in the middle of a debounce discards the press.
    cycles(10);
    btn = 1'b0;
    cycles(6);
    rst_in = 1'b1;
    cycles(3);
    btn = 1'b1;
    cycles(2);
    rst_in = 1'b0;
    chk("rst2_pattern", pattern_sel, 8'd0);
    chk("rst2_blank", blank, 8'd1);
    to_frame();
    to_frame();
    chk("rst2_run_blank", blank, 8'd0);
    chk("rst2_no_pending", busy, 8'd0);

    // Four presses two frames apart: 1, 2, 3, 0.
    for (int p = 0; p < 4; p++) begin
      press_release();
      to_frame();
      chk("seq_sel", pattern_sel, 8'((p + 1) % 4));
      chk("seq_blank", blank, 8'd1);
      to_frame();
      chk("seq_run_blank", blank, 8'd0);
    end

    // Press during the switch frame is held and serviced in RUN.
    press_release();
    to_frame();
    chk("sw_press_sel", pattern_sel, 8'd1);
    press_release();
    cycles(20);
    chk("sw_press_busy", busy, 8'd1);
    to_frame();
    chk("sw_latched_blank", blank, 8'd0);
    chk("sw_latched_sel", pattern_sel, 8'd1);
    chk("sw_latched_busy", busy, 8'd1);
    to_frame();
    chk("sw_serviced_sel", pattern_sel, 8'd2);
    chk("sw_serviced_blank", blank, 8'd1);
`endif

    chk("mid_frame_changes", 8'(mid_changes), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
